// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-field width and the hazard sequencer state encoding.
// Pure declarations; no timing or flow-control behaviour of its own.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        HALT      = 2'd2
    } hzd_state_t;

    // A MEM-stage access that is still outstanding this cycle.
    function automatic logic dmem_miss(input logic dren, input logic dwen, input logic hit);
        return (dren | dwen) & ~hit;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds a source operand of the instruction in ID.
// Purely combinational, zero latency; r0 is never a hazard because it is hardwired to zero.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_dren,
    input  regbits_t ex_dest,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    output logic     lu_hazard
);

    assign lu_hazard = ex_dren
                     && (ex_dest != '0)
                     && ((ex_dest == id_rs) || (ex_dest == id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes, combinational from state+inputs (same cycle).
// A dcache miss freezes every stage until dhit; halt freezes everything until reset.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             ex_dren,
    input  regbits_t         ex_dest,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    hzd_state_t state, next_state;
    logic       lu_hazard;
    logic       stall_inc, flush_inc;
    logic       do_run;
    logic [6:0] ctl;

    load_use_detect u_lu (
        .ex_dren   (ex_dren),
        .ex_dest   (ex_dest),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .lu_hazard (lu_hazard)
    );

    // ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    always_comb begin
        ctl        = 7'b0;
        next_state = state;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        do_run     = 1'b0;

        case (state)
            RUN: begin
                if (wb_halt) begin
                    next_state = HALT;
                end else if (dmem_miss(mem_dren, mem_dwen, dhit)) begin
                    next_state = DMEM_WAIT;
                    stall_inc  = 1'b1;
                end else begin
                    do_run = 1'b1;
                end
            end
            DMEM_WAIT: begin
                if (!dhit) begin
                    stall_inc = 1'b1;
                end else begin
                    do_run     = 1'b1;
                    next_state = RUN;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = RUN;
            end
        endcase

        // Redirect wins over load-use and fetch miss: both younger slots are squashed.
        if (do_run) begin
            if (ex_redirect) begin
                ctl       = 7'b1111111;
                flush_inc = 1'b1;
            end else if (lu_hazard) begin
                ctl       = 7'b0001111;
                stall_inc = 1'b1;
            end else if (!ihit) begin
                ctl       = 7'b0011011;
                stall_inc = 1'b1;
            end else begin
                ctl = 7'b1101011;
            end
        end
    end

    assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en} =
        nRST ? ctl : 7'b0;

    assign halted = (state == HALT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= next_state;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a 4-bit counter build to reach saturation.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam logic [6:0] CTL_RUN  = 7'b1101011;
    localparam logic [6:0] CTL_NONE = 7'b0000000;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             ihit, dhit, mem_dren, mem_dwen;
    logic [4:0]       id_rs, id_rt, ex_dest;
    logic             ex_dren, ex_redirect, wb_halt;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       ctl;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .mem_dren    (mem_dren),
        .mem_dwen    (mem_dwen),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_dren     (ex_dren),
        .ex_dest     (ex_dest),
        .ex_redirect (ex_redirect),
        .wb_halt     (wb_halt),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .idex_flush  (idex_flush),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 CLK = ~CLK;

    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic quiet();
        ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
        id_rs = 5'd1; id_rt = 5'd2; ex_dren = 1'b0; ex_dest = 5'd3;
        ex_redirect = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        quiet();
        nRST = 1'b0;

        // T1 reset
        tick(); mid();
        check("t1_rst_ctl", 32'(ctl), 32'(CTL_NONE));
        check("t1_rst_stall", 32'(stall_cnt), 0);
        check("t1_rst_flush", 32'(flush_cnt), 0);
        check("t1_rst_halted", 32'(halted), 0);
        tick(); nRST = 1'b1;
        mid();
        check("t1_run_ctl", 32'(ctl), 32'(CTL_RUN));

        // T2 load-use on rt
        tick();
        ex_dren = 1'b1; ex_dest = 5'd5; id_rt = 5'd5;
        mid();
        check("t2_lu_pc_en", 32'(pc_en), 0);
        check("t2_lu_ifid_en", 32'(ifid_en), 0);
        check("t2_lu_idex_flush", 32'(idex_flush), 1);
        check("t2_lu_memwb_en", 32'(memwb_en), 1);
        tick();
        ex_dren = 1'b0;
        check("t2_lu_stall_cnt", 32'(stall_cnt), 1);
        mid();
        check("t2_after_ctl", 32'(ctl), 32'(CTL_RUN));
        // r0 destination never stalls
        ex_dren = 1'b1; ex_dest = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        mid();
        check("t2_r0_ctl", 32'(ctl), 32'(CTL_RUN));
        tick();
        check("t2_r0_stall_cnt", 32'(stall_cnt), 1);
        // load-use on rs
        ex_dest = 5'd7; id_rs = 5'd7; id_rt = 5'd2;
        mid();
        check("t2_rs_pc_en", 32'(pc_en), 0);
        tick();
        check("t2_rs_stall_cnt", 32'(stall_cnt), 2);

        // T3 redirect overrides fetch miss
        do_reset();
        ex_redirect = 1'b1; ihit = 1'b0;
        mid();
        check("t3_pc_en", 32'(pc_en), 1);
        check("t3_ifid_flush", 32'(ifid_flush), 1);
        check("t3_idex_flush", 32'(idex_flush), 1);
        check("t3_exmem_en", 32'(exmem_en), 1);
        tick();
        check("t3_flush_cnt", 32'(flush_cnt), 1);
        check("t3_stall_cnt", 32'(stall_cnt), 0);
        // redirect beats load-use
        ihit = 1'b1; ex_dren = 1'b1; ex_dest = 5'd5; id_rt = 5'd5;
        mid();
        check("t3_vs_lu_pc_en", 32'(pc_en), 1);
        tick();
        check("t3_vs_lu_flush_cnt", 32'(flush_cnt), 2);
        check("t3_vs_lu_stall_cnt", 32'(stall_cnt), 0);

        // icache miss alone
        quiet(); ihit = 1'b0;
        mid();
        check("t3_imiss_pc_en", 32'(pc_en), 0);
        check("t3_imiss_ifid_flush", 32'(ifid_flush), 1);
        check("t3_imiss_idex_en", 32'(idex_en), 1);
        tick();
        check("t3_imiss_stall_cnt", 32'(stall_cnt), 1);

        // T4 dcache miss for three cycles
        do_reset();
        mem_dren = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check($sformatf("t4_miss_ctl%0d", i), 32'(ctl), 32'(CTL_NONE));
            tick();
        end
        dhit = 1'b1;
        mid();
        check("t4_hit_ctl", 32'(ctl), 32'(CTL_RUN));
        tick();
        check("t4_stall_cnt", 32'(stall_cnt), 3);
        mem_dren = 1'b0; dhit = 1'b0;
        mid();
        check("t4_back_run_ctl", 32'(ctl), 32'(CTL_RUN));

        // dcache miss with a redirect waiting in EX
        do_reset();
        mem_dren = 1'b1; dhit = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            check($sformatf("t4r_miss_ctl%0d", i), 32'(ctl), 32'(CTL_NONE));
            tick();
        end
        check("t4r_flush_held", 32'(flush_cnt), 0);
        dhit = 1'b1;
        mid();
        check("t4r_hit_pc_en", 32'(pc_en), 1);
        check("t4r_hit_ifid_flush", 32'(ifid_flush), 1);
        check("t4r_hit_idex_flush", 32'(idex_flush), 1);
        tick();
        check("t4r_flush_cnt", 32'(flush_cnt), 1);
        check("t4r_stall_cnt", 32'(stall_cnt), 3);

        // reset pulse mid-DMEM_WAIT returns to RUN
        do_reset();
        mem_dren = 1'b1; dhit = 1'b0;
        tick();
        nRST = 1'b0; #2; nRST = 1'b1;
        mem_dren = 1'b0;
        mid();
        check("t4_rst_in_wait_ctl", 32'(ctl), 32'(CTL_RUN));

        // T5 halt wins over a simultaneous dcache miss
        do_reset();
        wb_halt = 1'b1; mem_dren = 1'b1; dhit = 1'b0;
        mid();
        check("t5_halt_ctl", 32'(ctl), 32'(CTL_NONE));
        tick();
        wb_halt = 1'b0;
        check("t5_halted", 32'(halted), 1);
        for (int i = 0; i < 4; i++) begin
            ihit = i[0]; dhit = ~i[0]; mem_dren = i[1];
            mid();
            check($sformatf("t5_frozen_ctl%0d", i), 32'(ctl), 32'(CTL_NONE));
            tick();
        end
        check("t5_still_halted", 32'(halted), 1);
        check("t5_stall_frozen", 32'(stall_cnt), 0);
        nRST = 1'b0;
        mid();
        check("t5_rst_clears_halted", 32'(halted), 0);
        nRST = 1'b1;

        // T6 saturation with 20 consecutive fetch misses
        do_reset();
        ihit = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("t6_cnt14", 32'(stall_cnt), 14);
            if (i == 15) check("t6_cnt15", 32'(stall_cnt), 15);
        end
        check("t6_cnt_sat", 32'(stall_cnt), 15);
        check("t6_flush_zero", 32'(flush_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
